// File: rtl/dimm_emu_pkg.sv
// Shared types and default geometry for the DDR4 DIMM emulator.
package dimm_emu_pkg;

    localparam int RANKS_D        = 1;
    localparam int CHIPS_D        = 16;
    localparam int BGWIDTH_D      = 2;
    localparam int BAWIDTH_D      = 2;
    localparam int DEVICE_WIDTH_D = 4;
    localparam int CHWIDTH_D      = 5;
    localparam int COLWIDTH_D     = 10;

    localparam int DQWIDTH       = DEVICE_WIDTH_D * CHIPS_D;
    localparam int BANKGROUPS    = 2 ** BGWIDTH_D;
    localparam int BANKSPERGROUP = 2 ** BAWIDTH_D;
    localparam int SLOT_AW       = $clog2(RANKS_D * BANKGROUPS * BANKSPERGROUP) + CHWIDTH_D + COLWIDTH_D;

    typedef enum logic [2:0] {CMD_NOP, CMD_ACT, CMD_RD, CMD_WR, CMD_PRE, CMD_OTHER} cmd_e;
    typedef enum logic {BANK_IDLE, BANK_ACTIVE} bank_state_e;
    typedef enum logic [1:0] {ST_READY, ST_WRITE, ST_READ, ST_CLONE} emu_state_e;

    // rcw is {RAS_n, CAS_n, WE_n} carried on A[16:14] when act_n is high.
    function automatic cmd_e decode_cmd(input logic act_n, input logic [2:0] rcw);
        if (!act_n) return CMD_ACT;
        case (rcw)
            3'b100:  return CMD_WR;
            3'b101:  return CMD_RD;
            3'b010:  return CMD_PRE;
            3'b111:  return CMD_NOP;
            default: return CMD_OTHER;
        endcase
    endfunction

endpackage

// File: rtl/dimm_emu_bank.sv
// One rank x bank open-row tracker: IDLE/ACTIVE state plus the latched row.
module dimm_emu_bank
    import dimm_emu_pkg::*;
#(
    parameter int ADDRWIDTH = 17
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 act,
    input  logic                 pre,
    input  logic                 load,
    input  logic                 sync,
    input  logic [ADDRWIDTH-1:0] row_in,
    output bank_state_e          state,
    output logic [ADDRWIDTH-1:0] row
);

    // load forces the bank open on a new row (end of a row clone).
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= BANK_IDLE;
            row   <= '0;
        end else if (load) begin
            state <= BANK_ACTIVE;
            row   <= row_in;
        end else if (pre) begin
            state <= BANK_IDLE;
        end else if (act && sync && state == BANK_IDLE) begin
            state <= BANK_ACTIVE;
            row   <= row_in;
        end
    end

endmodule

// File: rtl/dimm_emu.sv
// Cycle-level DDR4 DIMM emulator: command decode, per-bank row tracking, burst storage.
// Optional row-clone on ACT to an open bank is enabled by defining ROWCLONE_EN.
module dimm_emu
    import dimm_emu_pkg::*;
#(
    parameter int RANKS        = RANKS_D,
    parameter int CHIPS        = CHIPS_D,
    parameter int BGWIDTH      = BGWIDTH_D,
    parameter int BAWIDTH      = BAWIDTH_D,
    parameter int ADDRWIDTH    = 17,
    parameter int COLWIDTH     = COLWIDTH_D,
    parameter int DEVICE_WIDTH = DEVICE_WIDTH_D,
    parameter int BL           = 8,
    parameter int CHWIDTH      = CHWIDTH_D,
    localparam int DQW         = DEVICE_WIDTH * CHIPS,
    localparam int NB          = (2 ** BGWIDTH) * (2 ** BAWIDTH)
) (
    input  logic                 ck_t,
    input  logic                 reset_n,
    input  logic                 cke,
    input  logic [RANKS-1:0]     cs_n,
    input  logic                 act_n,
    input  logic [ADDRWIDTH-1:0] A,
    input  logic [BAWIDTH-1:0]   ba,
    input  logic [BGWIDTH-1:0]   bg,
    inout  wire  [DQW-1:0]       dq,
    inout  wire  [CHIPS-1:0]     dqs_t,
    inout  wire  [CHIPS-1:0]     dqs_c,
    input  logic                 odt,
    input  logic                 parity,
    input  logic [NB-1:0]        sync
);

    localparam int NBT  = RANKS * NB;
    localparam int GBW  = (NBT > 1) ? $clog2(NBT) : 1;
    localparam int RKW  = (RANKS > 1) ? $clog2(RANKS) : 1;
    localparam int LBL  = $clog2(BL);
    localparam int SAW  = GBW + CHWIDTH + COLWIDTH;
    localparam int CNTW = (COLWIDTH > LBL) ? COLWIDTH : LBL;

    emu_state_e            state;
    logic [CNTW-1:0]       cnt;
    logic                  rd_en;
    logic [DQW-1:0]        rd_q;
    logic [GBW-1:0]        b_bank;
    logic [CHWIDTH-1:0]    b_row;
    logic [COLWIDTH-1:0]   b_col;

    cmd_e                  cmd;
    logic                  cs_any;
    logic [RKW-1:0]        sel_rank;
    logic [GBW-1:0]        gsel;
    bank_state_e           bank_state [NBT];
    logic [ADDRWIDTH-1:0]  bank_row [NBT];
    logic [ADDRWIDTH-1:0]  bank_row_in;
    logic [CHWIDTH-1:0]    sel_row_slot;
    logic                  accept, rw_ok, do_act, do_pre, do_wr, do_rd, do_clone;
    logic                  clone_load;
    logic [GBW-1:0]        clone_bank;
    logic [ADDRWIDTH-1:0]  clone_row;

    logic                  mem_we;
    logic [SAW-1:0]        mem_waddr, mem_raddr;
    logic [DQW-1:0]        mem_wdata;
    logic [DQW-1:0]        mem [2 ** SAW];

    logic unused_pins;
    assign unused_pins = ^{odt, parity};

    function automatic logic [COLWIDTH-1:0] beat_col(input logic [COLWIDTH-1:0] base,
                                                     input logic [CNTW-1:0] k);
        beat_col = {base[COLWIDTH-1:LBL], base[LBL-1:0] + k[LBL-1:0]};
    endfunction

    // Lowest-numbered rank with cs_n low owns the command.
    always_comb begin
        cs_any   = 1'b0;
        sel_rank = '0;
        for (int r = RANKS - 1; r >= 0; r--) begin
            if (!cs_n[r]) begin
                cs_any   = 1'b1;
                sel_rank = RKW'(r);
            end
        end
    end

    // A command is taken only on an idle emulator; anything arriving mid-burst or mid-clone is dropped.
    assign cmd          = decode_cmd(act_n, A[16:14]);
    assign gsel         = GBW'(int'(sel_rank) * NB + int'({bg, ba}));
    assign sel_row_slot = bank_row[gsel][CHWIDTH-1:0];
    assign accept       = reset_n && cke && cs_any && (state == ST_READY);
    assign rw_ok        = accept && (bank_state[gsel] == BANK_ACTIVE) && sync[{bg, ba}];
    assign do_act       = accept && (cmd == CMD_ACT);
    assign do_pre       = accept && (cmd == CMD_PRE);
    assign do_wr        = rw_ok && (cmd == CMD_WR);
    assign do_rd        = rw_ok && (cmd == CMD_RD);
    assign bank_row_in  = clone_load ? clone_row : A;

`ifdef ROWCLONE_EN
    logic [CHWIDTH-1:0]   b_src;
    logic [ADDRWIDTH-1:0] b_full_row;
    assign do_clone   = rw_ok && (cmd == CMD_ACT);
    assign clone_load = (state == ST_CLONE) && (cnt == CNTW'(2 ** COLWIDTH - 1));
    assign clone_bank = b_bank;
    assign clone_row  = b_full_row;
`else
    assign do_clone   = 1'b0;
    assign clone_load = 1'b0;
    assign clone_bank = '0;
    assign clone_row  = '0;
`endif

    for (genvar g = 0; g < NBT; g++) begin : g_bank
        localparam int R = g / NB;
        logic act_i, pre_i, load_i;
        wire  unused_row_hi = ^bank_row[g][ADDRWIDTH-1:CHWIDTH];
        assign act_i  = do_act && (gsel == GBW'(g));
        assign pre_i  = do_pre && (A[10] ? (sel_rank == RKW'(R)) : (gsel == GBW'(g)));
        assign load_i = clone_load && (clone_bank == GBW'(g));
        dimm_emu_bank #(.ADDRWIDTH(ADDRWIDTH)) u_bank (
            .clk     (ck_t),
            .reset_n (reset_n),
            .act     (act_i),
            .pre     (pre_i),
            .load    (load_i),
            .sync    (sync[g % NB]),
            .row_in  (bank_row_in),
            .state   (bank_state[g]),
            .row     (bank_row[g])
        );
    end

    always_ff @(posedge ck_t) begin
        if (!reset_n) begin
            state <= ST_READY;
            cnt   <= '0;
            rd_en <= 1'b0;
        end else begin
            case (state)
                ST_READY: begin
                    rd_en  <= do_rd;
                    cnt    <= do_clone ? '0 : CNTW'(1);
                    b_bank <= gsel;
                    b_row  <= do_clone ? A[CHWIDTH-1:0] : sel_row_slot;
                    b_col  <= A[COLWIDTH-1:0];
`ifdef ROWCLONE_EN
                    b_src      <= sel_row_slot;
                    b_full_row <= A;
`endif
                    if (do_wr)         state <= ST_WRITE;
                    else if (do_rd)    state <= ST_READ;
                    else if (do_clone) state <= ST_CLONE;
                end
                ST_WRITE, ST_READ: begin
                    cnt <= cnt + CNTW'(1);
                    if (cnt == CNTW'(BL - 1)) state <= ST_READY;
                end
                ST_CLONE: begin
                    cnt <= cnt + CNTW'(1);
                    if (cnt == CNTW'(2 ** COLWIDTH - 1)) state <= ST_READY;
                end
                default: state <= ST_READY;
            endcase
        end
    end

    // Beat 0 of a write is taken straight off the bus on the command edge.
    always_comb begin
        mem_we    = do_wr;
        mem_waddr = {gsel, sel_row_slot, A[COLWIDTH-1:0]};
        mem_wdata = dq;
        mem_raddr = {gsel, sel_row_slot, A[COLWIDTH-1:0]};
        if (state == ST_WRITE) begin
            mem_we    = reset_n;
            mem_waddr = {b_bank, b_row, beat_col(b_col, cnt)};
        end
`ifdef ROWCLONE_EN
        if (state == ST_CLONE) begin
            mem_we    = reset_n;
            mem_waddr = {b_bank, b_row, cnt[COLWIDTH-1:0]};
            mem_wdata = mem[{b_bank, b_src, cnt[COLWIDTH-1:0]}];
        end
`endif
        if (state == ST_READ) mem_raddr = {b_bank, b_row, beat_col(b_col, cnt)};
    end

    always_ff @(posedge ck_t) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    always_ff @(posedge ck_t) begin
        if (do_rd || state == ST_READ) rd_q <= mem[mem_raddr];
    end

    assign dq    = rd_en ? rd_q : {DQW{1'bz}};
    assign dqs_t = rd_en ? {CHIPS{1'b1}} : {CHIPS{1'bz}};
    assign dqs_c = rd_en ? {CHIPS{1'b0}} : {CHIPS{1'bz}};

endmodule

// File: tb/tb_dimm_emu.sv
// Directed bench for dimm_emu: write/read bursts, wrap order, ignored commands, precharge-all, reset abort.
module tb_dimm_emu;

    logic        ck_t = 1'b0;
    logic        reset_n = 1'b0;
    logic        cke = 1'b0;
    logic [0:0]  cs_n = 1'b1;
    logic        act_n = 1'b1;
    logic [16:0] A = 17'h1C000;
    logic [1:0]  ba = '0;
    logic [1:0]  bg = '0;
    logic        odt = 1'b0;
    logic        parity = 1'b0;
    logic [15:0] sync = 16'hFFFF;
    wire  [63:0] dq;
    wire  [15:0] dqs_t;
    wire  [15:0] dqs_c;

    logic        tb_dq_en = 1'b0;
    logic [63:0] tb_dq = '0;
    logic [63:0] exp_beats [8];
    int          n_cmp = 0;
    int          n_bad = 0;

    localparam logic [63:0] D_BASE = 64'hD0D0_0000_0000_0000;
    localparam logic [63:0] E_BASE = 64'hE0E0_0000_0000_0000;
    localparam logic [63:0] F_BASE = 64'hF0F0_0000_0000_0000;
    localparam logic [63:0] B_BASE = 64'hBAD0_0000_0000_0000;
    localparam logic [63:0] G_BASE = 64'h6060_0000_0000_0000;

    assign dq = tb_dq_en ? tb_dq : {64{1'bz}};

    always #5 ck_t = ~ck_t;

    dimm_emu u_dut (
        .ck_t    (ck_t),
        .reset_n (reset_n),
        .cke     (cke),
        .cs_n    (cs_n),
        .act_n   (act_n),
        .A       (A),
        .ba      (ba),
        .bg      (bg),
        .dq      (dq),
        .dqs_t   (dqs_t),
        .dqs_c   (dqs_c),
        .odt     (odt),
        .parity  (parity),
        .sync    (sync)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge ck_t);
        #1;
    endtask

    task automatic set_nop;
        cs_n  = 1'b1;
        act_n = 1'b1;
        A     = 17'h1C000;
    endtask

    task automatic set_act(input logic [1:0] g, input logic [1:0] b, input logic [16:0] row);
        cs_n  = 1'b0;
        act_n = 1'b0;
        A     = row;
        bg    = g;
        ba    = b;
    endtask

    task automatic set_rw(input logic rd, input logic [1:0] g, input logic [1:0] b, input logic [9:0] col);
        cs_n   = 1'b0;
        act_n  = 1'b1;
        A      = '0;
        A[16]  = 1'b1;
        A[14]  = rd;
        A[9:0] = col;
        bg     = g;
        ba     = b;
    endtask

    task automatic set_pre(input logic all, input logic [1:0] g, input logic [1:0] b);
        cs_n  = 1'b0;
        act_n = 1'b1;
        A     = '0;
        A[15] = 1'b1;
        A[10] = all;
        bg    = g;
        ba    = b;
    endtask

    task automatic do_act(input logic [1:0] g, input logic [1:0] b, input logic [16:0] row);
        set_act(g, b, row);
        tick;
        set_nop;
    endtask

    task automatic do_pre(input logic all, input logic [1:0] g, input logic [1:0] b);
        set_pre(all, g, b);
        tick;
        set_nop;
    endtask

    task automatic do_write(input logic [1:0] g, input logic [1:0] b, input logic [9:0] col,
                            input logic [63:0] base);
        set_rw(1'b0, g, b, col);
        tb_dq_en = 1'b1;
        tb_dq    = base;
        tick;
        for (int k = 1; k < 8; k++) begin
            set_nop;
            tb_dq = base + 64'(k);
            tick;
        end
        tb_dq_en = 1'b0;
    endtask

    // disturb drives a precharge of the same bank on every busy cycle of the burst.
    task automatic do_read(input string tag, input logic [1:0] g, input logic [1:0] b,
                           input logic [9:0] col, input logic disturb);
        set_rw(1'b1, g, b, col);
        tick;
        for (int k = 0; k < 8; k++) begin
            if (disturb && k < 7) set_pre(1'b0, g, b);
            else set_nop;
            check_eq($sformatf("%s_dq%0d", tag, k), dq, exp_beats[k]);
            check_eq($sformatf("%s_dqs%0d", tag, k), {32'h0, dqs_t, dqs_c}, 64'h0000_0000_FFFF_0000);
            tick;
        end
        check_eq($sformatf("%s_end_idle", tag), {63'b0, dqs_t === 16'hFFFF}, 64'd0);
    endtask

    task automatic do_read_idle(input string tag, input logic [1:0] g, input logic [1:0] b,
                                input logic [9:0] col);
        set_rw(1'b1, g, b, col);
        tick;
        set_nop;
        for (int k = 0; k < 9; k++) begin
            check_eq($sformatf("%s_idle%0d", tag, k), {63'b0, dqs_t === 16'hFFFF}, 64'd0);
            tick;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        set_nop;
        reset_n = 1'b0;
        cke     = 1'b1;
        repeat (3) tick;
        check_eq("reset_idle", {63'b0, dqs_t === 16'hFFFF}, 64'd0);
        reset_n = 1'b1;
        tick;

        // Basic write / close / reopen / read; a precharge mid-burst must be dropped.
        do_act(2'd1, 2'd1, 17'd1);
        do_write(2'd1, 2'd1, 10'd2, D_BASE);
        do_pre(1'b0, 2'd1, 2'd1);
        do_act(2'd1, 2'd1, 17'd1);
        for (int k = 0; k < 8; k++) exp_beats[k] = D_BASE + 64'(k);
        do_read("basic", 2'd1, 2'd1, 10'd2, 1'b1);

        // Write from col 6, read from col 0: wrap inside the 8-column block.
        do_write(2'd1, 2'd1, 10'd6, E_BASE);
        exp_beats[0] = E_BASE + 64'd2;
        exp_beats[1] = E_BASE + 64'd3;
        exp_beats[2] = E_BASE + 64'd4;
        exp_beats[3] = E_BASE + 64'd5;
        exp_beats[4] = E_BASE + 64'd6;
        exp_beats[5] = E_BASE + 64'd7;
        exp_beats[6] = E_BASE + 64'd0;
        exp_beats[7] = E_BASE + 64'd1;
        do_read("wrap", 2'd1, 2'd1, 10'd0, 1'b0);

        // Unopened bank and sync=0 bank: no bus activity, write ignored.
        do_read_idle("noact", 2'd2, 2'd0, 10'd0);
        sync[5] = 1'b0;
        do_read_idle("nosync", 2'd1, 2'd1, 10'd0);
        do_write(2'd1, 2'd1, 10'd0, B_BASE);
        sync[5] = 1'b1;
        do_read("unchanged", 2'd1, 2'd1, 10'd0, 1'b0);

        // Precharge-all closes every bank of the rank.
        do_pre(1'b0, 2'd1, 2'd1);
        do_act(2'd0, 2'd0, 17'd3);
        do_act(2'd1, 2'd1, 17'd1);
        do_write(2'd0, 2'd0, 10'd0, F_BASE);
        for (int k = 0; k < 8; k++) exp_beats[k] = F_BASE + 64'(k);
        do_read("b00", 2'd0, 2'd0, 10'd0, 1'b0);
        do_pre(1'b1, 2'd2, 2'd3);
        do_read_idle("pall_b00", 2'd0, 2'd0, 10'd0);
        do_read_idle("pall_b11", 2'd1, 2'd1, 10'd0);

        // Reset asserted at write beat 3: beats 3..7 must not land.
        do_act(2'd1, 2'd1, 17'd1);
        set_rw(1'b0, 2'd1, 2'd1, 10'd0);
        tb_dq_en = 1'b1;
        tb_dq    = G_BASE;
        tick;
        for (int k = 1; k < 3; k++) begin
            set_nop;
            tb_dq = G_BASE + 64'(k);
            tick;
        end
        set_nop;
        tb_dq   = G_BASE + 64'd3;
        reset_n = 1'b0;
        tick;
        check_eq("rst_bus_idle", {63'b0, dqs_t === 16'hFFFF}, 64'd0);
        tb_dq = G_BASE + 64'd4;
        tick;
        tb_dq_en = 1'b0;
        reset_n  = 1'b1;
        tick;
        do_read_idle("rst_bank_idle", 2'd1, 2'd1, 10'd0);
        do_act(2'd1, 2'd1, 17'd1);
        exp_beats[0] = G_BASE + 64'd0;
        exp_beats[1] = G_BASE + 64'd1;
        exp_beats[2] = G_BASE + 64'd2;
        exp_beats[3] = E_BASE + 64'd5;
        exp_beats[4] = E_BASE + 64'd6;
        exp_beats[5] = E_BASE + 64'd7;
        exp_beats[6] = E_BASE + 64'd0;
        exp_beats[7] = E_BASE + 64'd1;
        do_read("after_rst", 2'd1, 2'd1, 10'd0, 1'b0);

`ifdef ROWCLONE_EN
        // ACT row 4 on the open bank clones row 1, then row 4 is open.
        do_act(2'd1, 2'd1, 17'd4);
        repeat (1024) tick;
        do_read("clone", 2'd1, 2'd1, 10'd0, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
